// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
//
// Purpose: computes {remainder, quotient} of opdata1_i / opdata2_i in WIDTH
// iterations. Signed operands are divided as magnitudes, and the signs are
// re-applied at the end. The remainder takes the sign of the dividend.
//
// Optional feature macro: DIV_ZERO_FLAG_EN. When it is defined, the divzero_o
// port exists.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       abort; takes priority over start_i
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//   divzero_o     divisor was zero (DIV_ZERO_FLAG_EN only)

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                 divzero_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH:0]    work_q;
  logic [WIDTH-1:0]    divisor_q;
  logic                sign1_q;
  logic                sign2_q;
  logic                signed_q;
  logic [2*WIDTH-1:0]  result_q;
  logic                ready_q;

  logic [WIDTH-1:0]    op1_abs_d;
  logic [WIDTH-1:0]    op2_abs_d;
  logic [WIDTH:0]      diff_d;
  logic [WIDTH-1:0]    quo_d;
  logic [WIDTH-1:0]    rem_d;
  logic                start_ok_d;

  assign start_ok_d = start_i && !annul_i;

  // Magnitudes of the operands. 0x80000000 negates to itself, and that is
  // the correct unsigned magnitude.
  assign op1_abs_d = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs_d = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Trial subtraction of the partial remainder. The extra top bit is the
  // borrow, and it tells whether the step is "does not fit".
  assign diff_d = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};

  // The work register is one bit to the left of a textbook layout. The
  // remainder therefore sits at [2W:W+1].
  assign quo_d = (signed_q && (sign1_q ^ sign2_q)) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign rem_d = (signed_q && sign1_q) ? -work_q[2*WIDTH:WIDTH+1] : work_q[2*WIDTH:WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_ok_d) begin
            cnt_q     <= '0;
            work_q    <= {{WIDTH{1'b0}}, op1_abs_d, 1'b0};
            divisor_q <= op2_abs_d;
            sign1_q   <= opdata1_i[WIDTH-1];
            sign2_q   <= opdata2_i[WIDTH-1];
            signed_q  <= signed_div_i;
            state_q   <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          result_q <= '0;
          if (annul_i) begin
            ready_q <= 1'b0;
            state_q <= FREE;
          end else begin
            ready_q <= 1'b1;
            state_q <= END;
          end
        end
        ON: begin
          if (annul_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= FREE;
          end else if (cnt_q != CW'(WIDTH)) begin
            if (diff_d[WIDTH]) begin
              work_q <= {work_q[2*WIDTH-1:0], 1'b0};
            end else begin
              work_q <= {diff_d[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
            end
            cnt_q <= cnt_q + CW'(1);
          end else begin
            result_q <= {rem_d, quo_d};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        END: begin
          if (!start_i || annul_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= FREE;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

`ifdef DIV_ZERO_FLAG_EN
  logic divzero_q;

  // Set on the same edge that enters BYZERO. Cleared on any return to FREE.
  always_ff @(posedge clk) begin
    if (rst) begin
      divzero_q <= 1'b0;
    end else if (state_q == FREE) begin
      divzero_q <= start_ok_d && (opdata2_i == '0);
    end else if (annul_i || (state_q == END && !start_i)) begin
      divzero_q <= 1'b0;
    end
  end

  assign divzero_o = divzero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        divzero_o;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .divzero_o    (divzero_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rem;
    logic [31:0] quo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready_o && lat < 100);
  endtask

  task automatic drop_and_check(input string name);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({name, "_drop_result"}, result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check({name, "_drop_divzero"}, 64'(divzero_o), 64'd0);
`endif
  endtask

  initial begin
    int lat;
    int highs;
    logic [63:0] held;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'h1,          32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000};
    vecs[5]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd3,          32'h0,          32'h55555555};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd14};
    vecs[8]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};
    vecs[9]  = '{1'b0, 32'd5,          32'd5,          32'd0,          32'd1};
    vecs[10] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'd1,          32'h7FFFFFFC};
    vecs[11] = '{1'b0, 32'd9,          32'd0,          32'd0,          32'd0};
    vecs[12] = '{1'b1, 32'h7FFFFFFF,   32'h10,         32'hF,          32'h07FFFFFF};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset_divzero", 64'(divzero_o), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_ready(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), (vecs[i].b == 0) ? 64'd2 : 64'd34);
      check($sformatf("v%0d_result", i), result_o, {vecs[i].rem, vecs[i].quo});
`ifdef DIV_ZERO_FLAG_EN
      check($sformatf("v%0d_divzero", i), 64'(divzero_o), (vecs[i].b == 0) ? 64'd1 : 64'd0);
`endif
      drop_and_check($sformatf("v%0d", i));
    end

    // Annul in the middle of ON: the result is never exposed, and the unit
    // is free again at once.
    start_op(1'b0, 32'hFFFFFFFF, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    highs = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready_o) highs++;
    end
    check("annul_no_ready", 64'(highs), 64'd0);
    start_op(1'b0, 32'd9, 32'd3);
    wait_ready(lat);
    check("restart_latency", 64'(lat), 64'd34);
    check("restart_result", result_o, {32'd0, 32'd3});
    drop_and_check("restart");

    // Annul in FREE blocks the start. The latency counts from annul release.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("free_annul_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    wait_ready(lat);
    check("free_annul_latency", 64'(lat), 64'd34);
    check("free_annul_result", result_o, {32'd2, 32'd14});
    drop_and_check("free_annul");

    // Synchronous reset in the middle of ON.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    highs = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready_o) highs++;
    end
    check("midrst_no_ready", 64'(highs), 64'd0);

    // Operand changes during ON are ignored. The result holds in END while
    // start_i stays high. In END, annul behaves like dropping start.
    start_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'h12345678; opdata2_i = 32'd0;
    wait_ready(lat);
    check("hold_latency", 64'(lat + 5), 64'd34);
    check("hold_result", result_o, {32'hFFFFFFFE, 32'd14});
    held = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (!ready_o || result_o !== {32'hFFFFFFFE, 32'd14}) held++;
    end
    check("hold_stable", held, 64'd0);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("end_annul_ready", 64'(ready_o), 64'd0);
    check("end_annul_result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
